// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program-counter sequencer with redirect priority and imem wait handling
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    input  logic        halt,
    output logic [31:0] curr_pc,
    output logic [31:0] nxt_pc,
    output logic        if_valid,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc,
    output logic        misaligned,
    output logic        halted,
    output logic [31:0] redirect_cnt
);

    typedef enum logic [1:0] {RUN, WAIT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] curr_pc_q, curr_pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        mis_q, mis_d;

    logic        redirect;
    logic        bad_tgt;
    logic [31:0] raw_tgt;
    logic [31:0] dest;

    assign redirect = (state_q != HALTED) && (exception || branch_taken || jump);
    assign raw_tgt  = exception ? EXC_VECTOR : (branch_taken ? branch_target : jump_target);
    // Misaligned branch/jump targets trap to the exception vector instead.
    assign bad_tgt  = redirect && !exception && (raw_tgt[1:0] != 2'b00);
    assign dest     = bad_tgt ? EXC_VECTOR : raw_tgt;

    always_comb begin
        state_d     = state_q;
        curr_pc_d   = curr_pc_q;
        epc_d       = epc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        cnt_d       = cnt_q;
        mis_d       = 1'b0;
        if_valid    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (state_q != HALTED) begin
            if (redirect) begin
                flush_if_id = 1'b1;
                flush_id_ex = exception || branch_taken;
                cnt_d       = cnt_q + 32'd1;
                mis_d       = bad_tgt;
                if (exception) begin
                    epc_d = exc_pc;
                end else if (bad_tgt) begin
                    epc_d = raw_tgt;
                end
                if (imem_ready) begin
                    curr_pc_d = dest;
                    pend_d    = 1'b0;
                    state_d   = RUN;
                end else begin
                    // Hold the fetch address until memory finishes the current request.
                    pend_d     = 1'b1;
                    pend_tgt_d = dest;
                    state_d    = WAIT;
                end
            end else if (pend_q) begin
                if (imem_ready) begin
                    curr_pc_d = pend_tgt_q;
                    pend_d    = 1'b0;
                    state_d   = RUN;
                end
            end else if (stall) begin
                state_d = RUN;
            end else if (!imem_ready) begin
                state_d = WAIT;
            end else if (halt) begin
                state_d  = HALTED;
                if_valid = 1'b1;
            end else begin
                curr_pc_d = curr_pc_q + 32'd4;
                if_valid  = 1'b1;
                state_d   = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            curr_pc_q  <= RESET_PC;
            epc_q      <= 32'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
            mis_q      <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            curr_pc_q  <= curr_pc_d;
            epc_q      <= epc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign curr_pc      = curr_pc_q;
    assign nxt_pc       = curr_pc_d;
    assign epc          = epc_q;
    assign misaligned   = mis_q;
    assign halted       = (state_q == HALTED);
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural fetch model
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ready = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        exception = 1'b0;
    logic [31:0] exc_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] curr_pc, nxt_pc, epc, redirect_cnt;
    logic        if_valid, flush_if_id, flush_id_ex, misaligned, halted;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(EXC)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
        .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .exception(exception), .exc_pc(exc_pc), .halt(halt),
        .curr_pc(curr_pc), .nxt_pc(nxt_pc), .if_valid(if_valid),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .epc(epc), .misaligned(misaligned), .halted(halted),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the fetch unit must remember, in specification terms.
    logic [31:0] m_pc, m_epc, m_ptgt, m_cnt;
    logic        m_pend, m_halted, m_mis;
    logic [31:0] e_tgt, e_dest, e_nxt;
    logic        e_redir, e_bad, e_valid, e_fif, e_fex;

    always @* begin
        e_tgt   = exception ? EXC : (branch_taken ? branch_target : jump_target);
        e_redir = !m_halted && (exception || branch_taken || jump);
        e_bad   = e_redir && !exception && (e_tgt[1:0] != 2'b00);
        e_dest  = e_bad ? EXC : e_tgt;
        e_fif   = e_redir;
        e_fex   = e_redir && (exception || branch_taken);
        e_valid = 1'b0;
        e_nxt   = m_pc;
        if (e_redir) begin
            if (imem_ready) e_nxt = e_dest;
        end else if (!m_halted && imem_ready) begin
            if (m_pend) begin
                e_nxt = m_ptgt;
            end else if (!stall) begin
                e_valid = 1'b1;
                e_nxt   = halt ? m_pc : m_pc + 32'd4;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'd0; m_epc <= 32'd0; m_ptgt <= 32'd0; m_cnt <= 32'd0;
            m_pend <= 1'b0; m_halted <= 1'b0; m_mis <= 1'b0;
        end else begin
            m_pc  <= e_nxt;
            m_mis <= e_bad;
            if (e_redir) begin
                m_cnt <= m_cnt + 32'd1;
                if (exception) m_epc <= exc_pc;
                else if (e_bad) m_epc <= e_tgt;
                m_pend <= !imem_ready;
                if (!imem_ready) m_ptgt <= e_dest;
            end else if (imem_ready && !m_halted) begin
                m_pend <= 1'b0;
                if (!m_pend && !stall && halt) m_halted <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) begin
            chk("curr_pc", curr_pc, m_pc);
            chk("nxt_pc", nxt_pc, e_nxt);
            chk("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
            chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_fif});
            chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e_fex});
            chk("epc", epc, m_epc);
            chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            chk("redirect_cnt", redirect_cnt, m_cnt);
        end
    end

    task automatic clear_inputs();
        imem_ready = 1'b1; stall = 1'b0; halt = 1'b0;
        jump = 1'b0; jump_target = 32'd0;
        branch_taken = 1'b0; branch_target = 32'd0;
        exception = 1'b0; exc_pc = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset is raised mid-cycle so the checks below see it act without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        clear_inputs();
        #1;
        chk("rst_curr_pc", curr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cnt", redirect_cnt, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        #1 reset = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("seq_pc0", curr_pc, 32'd0);
        chk("seq_valid0", {31'd0, if_valid}, 32'd1);
        tick(); chk("seq_pc4", curr_pc, 32'd4);
        tick(); chk("seq_pc8", curr_pc, 32'd8);
        tick(); chk("seq_pc12", curr_pc, 32'd12);
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick(); jump = 1'b0;
        chk("wrap_pre", curr_pc, 32'hFFFF_FFFC);
        tick(); chk("wrap_post", curr_pc, 32'd0);

        do_reset();
        repeat (8) tick();
        chk("br_start", curr_pc, 32'h20);
        branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1;
        #1;
        chk("br_flush_if", {31'd0, flush_if_id}, 32'd1);
        chk("br_flush_ex", {31'd0, flush_id_ex}, 32'd1);
        chk("br_if_valid", {31'd0, if_valid}, 32'd0);
        tick(); clear_inputs();
        chk("br_pc", curr_pc, 32'h80);
        chk("br_cnt", redirect_cnt, 32'd1);

        do_reset();
        repeat (16) tick();
        chk("wt_start", curr_pc, 32'h40);
        imem_ready = 1'b0;
        tick(); tick();
        jump = 1'b1; jump_target = 32'h200;
        #1;
        chk("wt_flush_if", {31'd0, flush_if_id}, 32'd1);
        chk("wt_flush_ex", {31'd0, flush_id_ex}, 32'd0);
        tick(); jump = 1'b0;
        chk("wt_hold", curr_pc, 32'h40);
        tick(); tick();
        imem_ready = 1'b1;
        #1;
        chk("wt_discard", {31'd0, if_valid}, 32'd0);
        tick();
        chk("wt_pc", curr_pc, 32'h200);

        exception = 1'b1; exc_pc = 32'h54; jump = 1'b1; jump_target = 32'h300;
        #1;
        chk("exc_flush_ex", {31'd0, flush_id_ex}, 32'd1);
        tick(); clear_inputs();
        chk("exc_pc", curr_pc, EXC);
        chk("exc_epc", epc, 32'h54);

        jump = 1'b1; jump_target = 32'h202;
        tick(); jump = 1'b0;
        chk("mis_pc", curr_pc, EXC);
        chk("mis_epc", epc, 32'h202);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        tick();
        chk("mis_clear", {31'd0, misaligned}, 32'd0);

        imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h400;
        tick(); jump = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h500;
        tick(); branch_taken = 1'b0;
        tick(); imem_ready = 1'b1;
        tick();
        chk("ovr_pc", curr_pc, 32'h500);
        chk("ovr_cnt", redirect_cnt, 32'd5);

        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h87;
        tick(); branch_taken = 1'b0; stall = 1'b1;
        tick(); imem_ready = 1'b1;
        tick(); stall = 1'b0;
        chk("wmis_pc", curr_pc, EXC);
        chk("wmis_epc", epc, 32'h87);
        imem_ready = 1'b0;
        tick(); tick();
        do_reset();
        tick(); tick();

        do_reset();
        repeat (24) tick();
        chk("h_start", curr_pc, 32'h60);
        halt = 1'b1;
        #1;
        chk("h_valid", {31'd0, if_valid}, 32'd1);
        tick(); halt = 1'b0;
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_pc", curr_pc, 32'h60);
        branch_taken = 1'b1; branch_target = 32'h80;
        #1;
        chk("h_ignore_valid", {31'd0, if_valid}, 32'd0);
        chk("h_ignore_flush", {31'd0, flush_if_id}, 32'd0);
        tick(); tick();
        chk("h_hold", curr_pc, 32'h60);
        do_reset();
        tick();
        chk("h_resume", curr_pc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
